rx_unit: RTL and testbench

//  Simple 8N1 RS-232 receive unit, counterpart of the miniuart Tx unit.

---
 rtl/rx_unit.sv | 137 +++++++++++++
 tb/tb_rx_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_unit.sv
// 8N1 RS-232 receiver with 16x oversampling and 3-sample mid-bit majority vote.
// Reports each byte with ready, framing-error and sticky overrun status.
module rx_unit #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       enable_i,
  input  logic       rxd_i,
  input  logic       read_i,
  output logic [7:0] data_o,
  output logic       ready_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CntHm1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CntH   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CntHp1 = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CntMax = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic                   r_s0;
  logic                   r_s1;
  logic [7:0]             r_data;
  logic                   r_ready;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic          w_rxd_s;
  logic          w_vote;
  logic          w_decide;
  logic          w_complete;
  logic [CW-1:0] w_cnt_next;

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd_i};
    end
  end

  always_comb begin
    w_rxd_s    = r_sync[SYNC_STAGES-1];
    w_vote     = (r_s0 & r_s1) | (r_s0 & w_rxd_s) | (r_s1 & w_rxd_s);
    w_decide   = enable_i && (r_cnt == CntHp1);
    w_complete = w_decide && (r_state == StStop);
    w_cnt_next = (r_cnt == CntMax) ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
    end else if (enable_i) begin
      case (r_state)
        StIdle: begin
          if (!w_rxd_s) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart, StData, StStop: begin
          r_cnt <= w_cnt_next;
          if (r_cnt == CntHm1) r_s0 <= w_rxd_s;
          if (r_cnt == CntH)   r_s1 <= w_rxd_s;
          if (w_decide) begin
            if (r_state == StStart) begin
              if (w_vote) begin
                r_state <= StIdle;
              end else begin
                r_state   <= StData;
                r_bit_idx <= '0;
              end
            end else if (r_state == StData) begin
              r_shift <= {w_vote, r_shift[7:1]};
              if (r_bit_idx == 3'd7) r_state <= StStop;
              else                   r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
              // A low stop bit parks in BREAK until the line returns high.
              r_state <= w_vote ? StIdle : StBreak;
            end
          end
        end
        StBreak: begin
          if (w_rxd_s) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_complete) begin
      r_data      <= r_shift;
      r_frame_err <= ~w_vote;
      r_ready     <= 1'b1;
      // A read in the completion cycle consumes the old byte, so no overrun.
      if (r_ready && !read_i)     r_overrun <= 1'b1;
      else if (r_ready && read_i) r_overrun <= 1'b0;
    end else if (read_i && r_ready) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data_o      = r_data;
  assign ready_o     = r_ready;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_rx_unit.sv
// Self-checking bench for rx_unit: table of frames plus hand-written corner sequences.
module tb_rx_unit;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       fe;
  logic       ovr;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic       read_after;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       fe;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  rx_unit #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .enable_i   (en),
    .rxd_i      (rxd),
    .read_i     (rd),
    .data_o     (data),
    .ready_o    (ready),
    .frame_err_o(fe),
    .overrun_o  (ovr),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; each bit lasts OS clocks, LSB first.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      step(OS);
    end
  endtask

  task automatic pulse_read();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int max);
    int n;
    n = 0;
    while (!ready && n < max) begin
      step(1);
      n++;
    end
    check(name, ready, 1'b1);
  endtask

  task automatic check_byte(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got byte %0h expected nothing queued", name, data);
    end else begin
      e = sb.pop_front();
      check({name, "_data"}, data, e.data);
      check({name, "_fe"}, fe, e.fe);
    end
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1};

    #12;
    check("rst_data", data, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_fe", fe, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_busy", busy, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(4);

    for (int i = 0; i < 6; i++) begin
      sb.push_back('{vecs[i].exp_data, vecs[i].exp_fe});
      send_frame(vecs[i].data, 1'b1);
      wait_ready($sformatf("v%0d_ready", i), 8);
      check_byte($sformatf("v%0d", i));
      check($sformatf("v%0d_ovr", i), ovr, vecs[i].exp_ovr);
      if (vecs[i].read_after) begin
        pulse_read();
        check($sformatf("v%0d_rd_ready", i), ready, 1'b0);
        check($sformatf("v%0d_rd_ovr", i), ovr, 1'b0);
      end
    end

    // Short low glitch is rejected by the start-bit vote.
    rxd = 1'b0;
    step(5);
    rxd = 1'b1;
    step(3);
    check("glitch_busy", busy, 1'b1);
    step(20);
    check("glitch_idle", busy, 1'b0);
    check("glitch_ready", ready, 1'b0);

    // Low stop bit with line held low: framing error, then BREAK.
    sb.push_back('{8'h00, 1'b1});
    send_frame(8'h00, 1'b0);
    wait_ready("brk_ready", 8);
    check_byte("brk");
    check("brk_ovr", ovr, 1'b0);
    check("brk_busy", busy, 1'b1);
    pulse_read();
    step(40);
    check("brk_hold_busy", busy, 1'b1);
    check("brk_hold_ready", ready, 1'b0);
    rxd = 1'b1;
    step(4);
    check("brk_release", busy, 1'b0);
    sb.push_back('{8'h5A, 1'b0});
    send_frame(8'h5A, 1'b1);
    wait_ready("post_brk_ready", 8);
    check_byte("post_brk");
    pulse_read();

    // Two unread bytes set overrun; a read in the completion clock of the third clears it.
    sb.push_back('{8'h11, 1'b0});
    send_frame(8'h11, 1'b1);
    wait_ready("or1_ready", 8);
    check_byte("or1");
    sb.push_back('{8'h22, 1'b0});
    send_frame(8'h22, 1'b1);
    check_byte("or2");
    check("or2_ovr", ovr, 1'b1);
    sb.push_back('{8'h33, 1'b0});
    fork
      send_frame(8'h33, 1'b1);
      begin
        step(156);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
      end
    join
    check_byte("rdc");
    check("rdc_ready", ready, 1'b1);
    check("rdc_ovr", ovr, 1'b0);

    // Asynchronous reset in the middle of data bit 4.
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (88) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_data", data, 8'h00);
        check("mrst_ready", ready, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ovr", ovr, 1'b0);
        step(1);
        rst_n = 1'b1;
      end
    join
    check("mrst_after_busy", busy, 1'b0);
    check("mrst_after_ready", ready, 1'b0);
    sb.push_back('{8'h81, 1'b0});
    send_frame(8'h81, 1'b1);
    wait_ready("post_rst_ready", 8);
    check_byte("post_rst");
    check("post_rst_ovr", ovr, 1'b0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
